// File: rtl/cp_link_arbiter_nch.sv
// ---------------------------------------------------------------------------
// cp_link_arbiter_nch
//
// N-phase control-panel link manager with dual-system (sysA / sysB)
// redundancy. Each phase watches the health of both decoded optical frame
// streams and picks one of them through a revertive selection FSM. It
// forwards the chosen payload toward the DSP/PWM side and keeps per-system
// good-frame ("renew") counters. A common read-interrupt strobe is raised
// once every live phase has delivered a frame.
//
// Parameters
//   N_PHASE    number of phase channels
//   DATA_W     payload width per frame
//   CNT_W      renew counter width
//   TIMEOUT    cycles without a good frame before a system is dead (>=2)
//   RECOVER_N  consecutive good sysA frames needed to revert from sysB (>=1)
//
// Ports
//   i_clk, i_reset_n           clock (rising edge), async active-low reset
//   i_frm_vld_A/B [N]          frame-complete strobe per phase
//   i_frm_err_A/B [N]          checksum error, qualified by the strobe
//   i_frm_data_A/B [N*DATA_W]  payload, phase k at [k*DATA_W +: DATA_W]
//   o_data [N*DATA_W]          selected payload, held between updates
//   o_data_vld [N]             1-cycle strobe when a phase slice updates
//   o_comsta [N*4]             per phase {lost, sel_B, alive_B, alive_A}
//   o_renew_cnt_A/B [N*CNT_W]  good-frame counters, wrap around
//   o_rdint                    1-cycle synchronisation strobe to the DSP
//
// Build option
//   CP_ARB_ZERO_ON_LOST_EN  when defined, a phase's o_data slice is cleared
//                           on the cycle after it enters LOST (no strobe).
// ---------------------------------------------------------------------------
module cp_link_arbiter_nch #(
  parameter int N_PHASE   = 3,
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 2000,
  parameter int RECOVER_N = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [N_PHASE-1:0]        i_frm_vld_A,
  input  logic [N_PHASE-1:0]        i_frm_err_A,
  input  logic [N_PHASE*DATA_W-1:0] i_frm_data_A,
  input  logic [N_PHASE-1:0]        i_frm_vld_B,
  input  logic [N_PHASE-1:0]        i_frm_err_B,
  input  logic [N_PHASE*DATA_W-1:0] i_frm_data_B,
  output logic [N_PHASE*DATA_W-1:0] o_data,
  output logic [N_PHASE-1:0]        o_data_vld,
  output logic [N_PHASE*4-1:0]      o_comsta,
  output logic [N_PHASE*CNT_W-1:0]  o_renew_cnt_A,
  output logic [N_PHASE*CNT_W-1:0]  o_renew_cnt_B,
  output logic                      o_rdint
);

  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int RUN_W = $clog2(RECOVER_N + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RECOVER_N);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_LOST  = 2'd0,
    ST_SEL_A = 2'd1,
    ST_SEL_B = 2'd2
  } state_t;

  // registered state
  state_t                    state_r    [N_PHASE];
  logic [TO_W-1:0]           to_cnt_a_r [N_PHASE];
  logic [TO_W-1:0]           to_cnt_b_r [N_PHASE];
  logic [RUN_W-1:0]          run_a_r    [N_PHASE];
  logic [N_PHASE-1:0]        pend_r;
  logic [N_PHASE*DATA_W-1:0] data_r;
  logic [N_PHASE-1:0]        data_vld_r;
  logic [N_PHASE*CNT_W-1:0]  cnt_a_r;
  logic [N_PHASE*CNT_W-1:0]  cnt_b_r;
  logic                      rdint_r;

  // combinational helpers
  state_t                    state_nxt_s [N_PHASE];
  logic [N_PHASE-1:0]        good_a_s;
  logic [N_PHASE-1:0]        good_b_s;
  logic [N_PHASE-1:0]        bad_a_s;
  logic [N_PHASE-1:0]        alive_a_s;
  logic [N_PHASE-1:0]        alive_b_s;
  logic [N_PHASE-1:0]        live_s;
  logic [N_PHASE-1:0]        fwd_s;
  logic [N_PHASE*DATA_W-1:0] fwd_data_s;
  logic                      issue_s;

  // Frame qualification and health decode from the registered timeout counters
  always_comb begin
    good_a_s  = i_frm_vld_A & ~i_frm_err_A;
    good_b_s  = i_frm_vld_B & ~i_frm_err_B;
    bad_a_s   = i_frm_vld_A & i_frm_err_A;
    alive_a_s = '0;
    alive_b_s = '0;
    for (int k = 0; k < N_PHASE; k++) begin
      alive_a_s[k] = (to_cnt_a_r[k] < TO_MAX);
      alive_b_s[k] = (to_cnt_b_r[k] < TO_MAX);
    end
  end

  // Timeout counters per system and the sysA good-run counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N_PHASE; k++) begin
        to_cnt_a_r[k] <= TO_MAX;
        to_cnt_b_r[k] <= TO_MAX;
        run_a_r[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < N_PHASE; k++) begin
        if (good_a_s[k]) begin
          to_cnt_a_r[k] <= '0;
        end else if (to_cnt_a_r[k] != TO_MAX) begin
          to_cnt_a_r[k] <= to_cnt_a_r[k] + TO_ONE;
        end
        if (good_b_s[k]) begin
          to_cnt_b_r[k] <= '0;
        end else if (to_cnt_b_r[k] != TO_MAX) begin
          to_cnt_b_r[k] <= to_cnt_b_r[k] + TO_ONE;
        end
        // an error frame breaks the run; a good frame extends it even if it
        // is the one reviving a dead sysA; a dead sysA otherwise clears it
        if (bad_a_s[k]) begin
          run_a_r[k] <= '0;
        end else if (good_a_s[k]) begin
          if (run_a_r[k] != RUN_MAX) begin
            run_a_r[k] <= run_a_r[k] + RUN_ONE;
          end
        end else if (!alive_a_s[k]) begin
          run_a_r[k] <= '0;
        end
      end
    end
  end

  // Revertive selection FSM, next-state logic
  always_comb begin
    for (int k = 0; k < N_PHASE; k++) begin
      state_nxt_s[k] = state_r[k];
      case (state_r[k])
        ST_SEL_A: begin
          if (!alive_a_s[k]) begin
            state_nxt_s[k] = alive_b_s[k] ? ST_SEL_B : ST_LOST;
          end else begin
            state_nxt_s[k] = ST_SEL_A;
          end
        end
        ST_SEL_B: begin
          if (!alive_b_s[k]) begin
            state_nxt_s[k] = alive_a_s[k] ? ST_SEL_A : ST_LOST;
          end else if (alive_a_s[k] && (run_a_r[k] == RUN_MAX)) begin
            state_nxt_s[k] = ST_SEL_A;
          end else begin
            state_nxt_s[k] = ST_SEL_B;
          end
        end
        ST_LOST: begin
          if (alive_a_s[k]) begin
            state_nxt_s[k] = ST_SEL_A;
          end else if (alive_b_s[k]) begin
            state_nxt_s[k] = ST_SEL_B;
          end else begin
            state_nxt_s[k] = ST_LOST;
          end
        end
        default: state_nxt_s[k] = ST_LOST;
      endcase
    end
  end

  // Selection FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < N_PHASE; k++) begin
        state_r[k] <= ST_LOST;
      end
    end else begin
      for (int k = 0; k < N_PHASE; k++) begin
        state_r[k] <= state_nxt_s[k];
      end
    end
  end

  // Forward decision uses the pre-transition state; rdint issue condition
  always_comb begin
    fwd_s      = '0;
    live_s     = '0;
    fwd_data_s = '0;
    for (int k = 0; k < N_PHASE; k++) begin
      live_s[k] = (state_r[k] != ST_LOST);
      if (state_r[k] == ST_SEL_B) begin
        fwd_s[k]                        = good_b_s[k];
        fwd_data_s[k*DATA_W +: DATA_W] = i_frm_data_B[k*DATA_W +: DATA_W];
      end else begin
        fwd_s[k]                        = good_a_s[k] & (state_r[k] == ST_SEL_A);
        fwd_data_s[k*DATA_W +: DATA_W] = i_frm_data_A[k*DATA_W +: DATA_W];
      end
    end
    // LOST phases are excluded; with every phase LOST nothing is issued
    issue_s = (|live_s) & (&(~live_s | pend_r | fwd_s));
  end

  // Payload, strobes, pending flags and renew counters
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_r     <= '0;
      data_vld_r <= '0;
      pend_r     <= '0;
      cnt_a_r    <= '0;
      cnt_b_r    <= '0;
      rdint_r    <= 1'b0;
    end else begin
      data_vld_r <= fwd_s;
      rdint_r    <= issue_s;
      // a phase sitting in LOST must not carry a stale pending flag back in
      if (issue_s) begin
        pend_r <= '0;
      end else begin
        pend_r <= (pend_r | fwd_s) & live_s;
      end
      for (int k = 0; k < N_PHASE; k++) begin
        if (fwd_s[k]) begin
          data_r[k*DATA_W +: DATA_W] <= fwd_data_s[k*DATA_W +: DATA_W];
`ifdef CP_ARB_ZERO_ON_LOST_EN
        end else if (state_r[k] == ST_LOST) begin
          data_r[k*DATA_W +: DATA_W] <= '0;
`endif
        end
        if (good_a_s[k]) begin
          cnt_a_r[k*CNT_W +: CNT_W] <= cnt_a_r[k*CNT_W +: CNT_W] + CNT_ONE;
        end
        if (good_b_s[k]) begin
          cnt_b_r[k*CNT_W +: CNT_W] <= cnt_b_r[k*CNT_W +: CNT_W] + CNT_ONE;
        end
      end
    end
  end

  // Status nibble decoded purely from registered state
  always_comb begin
    o_comsta = '0;
    for (int k = 0; k < N_PHASE; k++) begin
      o_comsta[k*4 +: 4] = {(state_r[k] == ST_LOST), (state_r[k] == ST_SEL_B),
                            alive_b_s[k], alive_a_s[k]};
    end
  end

  assign o_data        = data_r;
  assign o_data_vld    = data_vld_r;
  assign o_renew_cnt_A = cnt_a_r;
  assign o_renew_cnt_B = cnt_b_r;
  assign o_rdint       = rdint_r;

endmodule

// File: tb/tb_cp_link_arbiter_nch.sv
// ---------------------------------------------------------------------------
// Testbench for cp_link_arbiter_nch. Stimulus pushes expected output events
// (strobe mask, payloads, rdint, arrival time) into a queue; a monitor on the
// falling clock edge pops and compares whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_cp_link_arbiter_nch;

  localparam int NP = 3;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int TO = 20;
  localparam int RN = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     va, ea, vb, eb;
  logic [NP*DW-1:0]  da, db;
  logic [NP*DW-1:0]  o_data;
  logic [NP-1:0]     o_data_vld;
  logic [NP*4-1:0]   o_comsta;
  logic [NP*CW-1:0]  o_renew_cnt_A, o_renew_cnt_B;
  logic              o_rdint;

  cp_link_arbiter_nch #(
    .N_PHASE(NP), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO), .RECOVER_N(RN)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_frm_vld_A(va), .i_frm_err_A(ea), .i_frm_data_A(da),
    .i_frm_vld_B(vb), .i_frm_err_B(eb), .i_frm_data_B(db),
    .o_data(o_data), .o_data_vld(o_data_vld), .o_comsta(o_comsta),
    .o_renew_cnt_A(o_renew_cnt_A), .o_renew_cnt_B(o_renew_cnt_B),
    .o_rdint(o_rdint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]    vld;
    logic [NP*DW-1:0] data;
    logic             rd;
    time              t;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   good_a[NP];
  int   good_b[NP];
  logic [DW-1:0] last_p1;

  function automatic void chk(input string name, input logic [NP*DW-1:0] act,
                              input logic [NP*DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // one frame cycle; call at posedge+1, returns at the next posedge+1
  task automatic send(input logic [2:0] a, input logic [2:0] ae,
                      input logic [2:0] b, input logic [2:0] be,
                      input logic [63:0] base_a, input logic [63:0] base_b,
                      input logic [2:0] x_fwd, input logic [2:0] x_srcb,
                      input logic x_rd);
    exp_t e;
    va = a; ea = ae; vb = b; eb = be;
    e.vld = x_fwd; e.rd = x_rd; e.t = $time + 14; e.data = '0;
    for (int k = 0; k < NP; k++) begin
      da[k*DW +: DW] = base_a + 64'(k);
      db[k*DW +: DW] = base_b + 64'(k);
      if (x_fwd[k]) e.data[k*DW +: DW] = x_srcb[k] ? base_b + 64'(k) : base_a + 64'(k);
      if (a[k] && !ae[k]) good_a[k]++;
      if (b[k] && !be[k]) good_b[k]++;
    end
    if (x_fwd != 3'b000 || x_rd) sbq.push_back(e);
    @(posedge clk); #1;
    va = '0; vb = '0; ea = '0; eb = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_renew();
    for (int k = 0; k < NP; k++) begin
      chk("renew_A", o_renew_cnt_A[k*CW +: CW], CW'(good_a[k]));
      chk("renew_B", o_renew_cnt_B[k*CW +: CW], CW'(good_b[k]));
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_data", o_data, '0);
    chk("rst_vld", o_data_vld, 3'b000);
    chk("rst_comsta", o_comsta, 12'h888);
    chk("rst_renewA", o_renew_cnt_A, 24'h0);
    chk("rst_renewB", o_renew_cnt_B, 24'h0);
    chk("rst_rdint", o_rdint, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].t < $time) begin
      mon_e = sbq.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_output: expected at t=%0t vld=%b rdint=%b, DUT strobe absent", mon_e.t, mon_e.vld, mon_e.rd);
    end
    if (o_data_vld != 3'b000 || o_rdint) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: actual vld=%b rdint=%b, required none", o_data_vld, o_rdint);
      end else begin
        mon_e = sbq.pop_front();
        chk("out_time", $time, mon_e.t);
        chk("out_vld", o_data_vld, mon_e.vld);
        chk("out_rdint", o_rdint, mon_e.rd);
        for (int k = 0; k < NP; k++) begin
          if (mon_e.vld[k]) chk("out_data", o_data[k*DW +: DW], mon_e.data[k*DW +: DW]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    va = '0; ea = '0; vb = '0; eb = '0; da = '0; db = '0;
    for (int k = 0; k < NP; k++) begin good_a[k] = 0; good_b[k] = 0; end
    idle(3);
    chk_reset_outputs();
    rst_n = 1'b1;

    // 1: sysA frames on all phases; first one only leaves LOST
    send(3'b111, 3'b000, 3'b000, 3'b000, 64'h1234, 64'h0, 3'b000, 3'b000, 1'b0);
    idle(9);
    chk("t1_comsta_selA", o_comsta, 12'h111);
    send(3'b111, 3'b000, 3'b000, 3'b000, 64'h1234, 64'h0, 3'b111, 3'b000, 1'b1);
    idle(9);
    send(3'b111, 3'b000, 3'b000, 3'b000, 64'h1234, 64'h0, 3'b111, 3'b000, 1'b1);
    idle(9);
    chk_renew();
    // split round: rdint waits for the last phase
    send(3'b110, 3'b000, 3'b000, 3'b000, 64'h5600, 64'h0, 3'b110, 3'b000, 1'b0);
    send(3'b001, 3'b000, 3'b000, 3'b000, 64'h7800, 64'h0, 3'b001, 3'b000, 1'b1);

    // 2: phase0 sysA stops, sysB continues
    for (int k = 1; k <= 21; k++) begin
      send(3'b110, 3'b000, 3'b001, 3'b000, 64'hA000 + 64'(k*16), 64'hB000 + 64'(k*16),
           3'b110, 3'b000, 1'b0);
      if (k == 19) chk("t2_nib_k19", o_comsta[3:0], 4'b0011);
      if (k == 20) chk("t2_nib_k20", o_comsta[3:0], 4'b0010);
      if (k == 21) chk("t2_nib_k21", o_comsta[3:0], 4'b0110);
    end
    for (int k = 22; k <= 23; k++) begin
      send(3'b110, 3'b000, 3'b001, 3'b000, 64'hA000 + 64'(k*16), 64'hB000 + 64'(k*16),
           3'b111, 3'b001, 1'b1);
    end

    // 3: sysA resumes: 3 good, 1 error, then good frames until revert
    for (int c = 1; c <= 10; c++) begin
      send(3'b111, (c == 4) ? 3'b001 : 3'b000, 3'b001, 3'b000,
           64'hC000 + 64'(c*16), 64'hD000 + 64'(c*16),
           3'b111, (c <= 9) ? 3'b001 : 3'b000, 1'b1);
      if (c == 3) chk("t3_nib_c3", o_comsta[3:0], 4'b0111);
      if (c == 8) chk("t3_nib_c8", o_comsta[3:0], 4'b0111);
      if (c == 9) chk("t3_nib_c9", o_comsta[3:0], 4'b0011);
    end
    last_p1 = 64'hC000 + 64'(10*16) + 64'd1;
    chk_renew();

    // 4: phase1 silent on both systems
    for (int k = 1; k <= 23; k++) begin
      send(3'b101, 3'b000, 3'b000, 3'b000, 64'hE000 + 64'(k*16), 64'h0,
           3'b101, 3'b000, (k >= 22) ? 1'b1 : 1'b0);
      if (k == 20) chk("t4_nib1_k20", o_comsta[7:4], 4'b0000);
      if (k == 21) chk("t4_nib1_k21", o_comsta[7:4], 4'b1000);
      if (k == 22) begin
        chk("t4_comsta", o_comsta, 12'h181);
`ifdef CP_ARB_ZERO_ON_LOST_EN
        chk("t4_data1_lost", o_data[DW +: DW], 64'h0);
`else
        chk("t4_data1_lost", o_data[DW +: DW], last_p1);
`endif
      end
    end

    // 5: renew_B on phase2 driven to wrap, simultaneous A+B forwards A only
    for (int i = 0; i < 255; i++) begin
      send(3'b101, 3'b000, 3'b100, 3'b000, 64'hF000, 64'hF100, 3'b101, 3'b000, 1'b1);
    end
    chk("t5_renewB2_full", o_renew_cnt_B[2*CW +: CW], 8'hFF);
    send(3'b101, 3'b000, 3'b100, 3'b000, 64'h1111_0000, 64'h2222_0000, 3'b101, 3'b000, 1'b1);
    chk("t5_renewB2_wrap", o_renew_cnt_B[2*CW +: CW], 8'h00);
    chk_renew();

    // 6: asynchronous reset during a frame cycle
    idle(2);
    va = 3'b111;
    for (int k = 0; k < NP; k++) da[k*DW +: DW] = 64'h5555 + 64'(k);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    va = '0;
    idle(2);
    chk("t6_vld_held", o_data_vld, 3'b000);
    chk("t6_comsta_held", o_comsta, 12'h888);
    rst_n = 1'b1;
    for (int k = 0; k < NP; k++) begin good_a[k] = 0; good_b[k] = 0; end
    send(3'b111, 3'b000, 3'b000, 3'b000, 64'h9000, 64'h0, 3'b000, 3'b000, 1'b0);
    chk("t6_comsta_alive", o_comsta, 12'h999);
    idle(1);
    chk("t6_comsta_selA", o_comsta, 12'h111);
    send(3'b111, 3'b000, 3'b000, 3'b000, 64'h9100, 64'h0, 3'b111, 3'b000, 1'b1);
    idle(3);
    chk_renew();
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
